// File: rtl/operand_feeder.sv
// rtl/operand_feeder.sv - operand FIFO and valid-tag tracker feeding the 4-stage bit pipeline
// Issues buffered words (or drain bubbles) into the pipeline and qualifies its result f.
module operand_feeder #(
   parameter int DEPTH    = 4,
   parameter bit DRAIN_EN = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   input  logic [4:0]             in_data,
   output logic                   in_ready,
   output logic                   load,
   output logic                   a,
   output logic                   b,
   output logic                   c,
   output logic                   d,
   output logic                   e,
   input  logic                   f,
   output logic                   f_valid,
   input  logic                   f_ready,
   output logic [$clog2(DEPTH):0] fifo_count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [4:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [3:0]    r_vld;

   logic w_empty;
   logic w_push;
   logic w_free;
   logic w_issue;
   logic w_bubble;
   logic w_load;
   logic w_unused;

   // f travels from reg4 straight to the consumer; this block only qualifies it
   assign w_unused = f;

   assign w_empty  = (r_count == '0);
   assign in_ready = (r_count != FULL_COUNT);
   assign w_push   = in_valid & in_ready;
   assign w_free   = ~r_vld[3] | f_ready;
   assign w_issue  = ~w_empty & w_free;
   assign w_bubble = DRAIN_EN & w_empty & (|r_vld[2:0]) & w_free;
   assign w_load   = w_issue | w_bubble;

   assign load       = w_load;
   assign f_valid    = r_vld[3];
   assign fifo_count = r_count;
   assign {a, b, c, d, e} = w_empty ? 5'b00000 : r_mem[r_rd_ptr];

   // Storage carries data only; occupancy is governed by r_count
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_issue) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_issue})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Tags shift with the pipeline; a consumed result drops its tag even when frozen
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_vld <= '0;
      end else if (w_load) begin
         r_vld <= {r_vld[2:0], w_issue};
      end else if (r_vld[3] & f_ready) begin
         r_vld[3] <= 1'b0;
      end
   end

endmodule
